game_ctrl: RTL

Top-level game flow controller for the rhythm game. It sequences the game timer and the note generator through idle, countdown, play, pause, tail and result phases. It enables the millisecond play clock, holds the note generator in reset outside a song, and gates player input. It also delays the result screen until the last note has scrolled off the LCD.

---
 rtl/game_ctrl_if.sv | 30 +++
 rtl/game_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/game_ctrl_if.sv
// Signal bundle between the rhythm-game flow controller and its surroundings
// (buttons, ms tick, note generator, game timer, display).
interface game_ctrl_if;
  // Inputs are sampled on the rising clk edge. Buttons and the tick are
  // one-cycle pulses, i_game_end is a level. There is no back-pressure:
  // every pulse seen at an edge is consumed at that edge or deliberately ignored.
  logic       i_tick_1ms;
  logic       i_btn_start;
  logic       i_btn_pause;
  logic       i_game_end;
  logic [2:0] o_state;
  logic       o_timer_en;
  logic       o_timer_clr;
  logic       o_gen_rst;
  logic       o_input_en;
  logic [2:0] o_digit;
  logic       o_result_pulse;

  modport master (
    output i_tick_1ms, i_btn_start, i_btn_pause, i_game_end,
    input  o_state, o_timer_en, o_timer_clr, o_gen_rst, o_input_en,
           o_digit, o_result_pulse
  );

  modport slave (
    input  i_tick_1ms, i_btn_start, i_btn_pause, i_game_end,
    output o_state, o_timer_en, o_timer_clr, o_gen_rst, o_input_en,
           o_digit, o_result_pulse
  );
endinterface

// File: rtl/game_ctrl.sv
// Game flow controller: idle -> countdown -> play/pause -> tail -> result.
// Drives game_timer enable/clear, note_gen reset and player input gating.
module game_ctrl #(
  parameter int COUNTDOWN_MS = 1000,
  parameter int COUNT_STEPS  = 3,
  parameter int TAIL_MS      = 2000
) (
  input logic        clk,
  input logic        rst,
  game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_TAIL      = 3'd4,
    S_RESULT    = 3'd5
  } state_t;

  localparam logic [15:0] CD_LAST    = 16'(COUNTDOWN_MS - 1);
  localparam logic [15:0] TAIL_LAST  = 16'(TAIL_MS - 1);
  localparam logic [2:0]  DIGIT_INIT = 3'(COUNT_STEPS);

  state_t      state_q, state_d;
  logic [15:0] ms_q, ms_d;
  logic [2:0]  digit_q, digit_d;

  logic timer_en_q, timer_en_d;
  logic timer_clr_q, timer_clr_d;
  logic gen_rst_q, gen_rst_d;
  logic input_en_q, input_en_d;
  logic pulse_q, pulse_d;

  // State, counter and digit registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ms_q    <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      digit_q <= digit_d;
    end
  end

  // Next-state logic. The ms counter is zeroed whenever the state changes,
  // so a tick coinciding with the entering event is never counted.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    ms_d    = ms_q;
    if (bus.i_tick_1ms) ms_d = ms_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.i_btn_start) begin
          state_d = S_COUNTDOWN;
          digit_d = DIGIT_INIT;
        end
      end
      S_COUNTDOWN: begin
        if (bus.i_btn_start) begin
          state_d = S_IDLE;
          digit_d = '0;
        end else if (bus.i_tick_1ms && (ms_q == CD_LAST)) begin
          ms_d    = '0;
          digit_d = digit_q - 3'd1;
          if (digit_q == 3'd1) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (bus.i_game_end)       state_d = S_TAIL;
        else if (bus.i_btn_pause) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (bus.i_btn_start)      state_d = S_IDLE;
        else if (bus.i_btn_pause) state_d = S_PLAY;
      end
      S_TAIL: begin
        if (bus.i_tick_1ms && (ms_q == TAIL_LAST)) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (bus.i_btn_start) begin
          state_d = S_COUNTDOWN;
          digit_d = DIGIT_INIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        digit_d = '0;
      end
    endcase

    if (state_d != state_q) ms_d = '0;
  end

  // Output decode of the upcoming state, registered below so outputs
  // change on the same edge as the state they belong to.
  always_comb begin
    timer_en_d  = 1'b0;
    timer_clr_d = 1'b1;
    gen_rst_d   = 1'b1;
    input_en_d  = 1'b0;
    case (state_d)
      S_PLAY, S_TAIL: begin
        timer_en_d  = 1'b1;
        timer_clr_d = 1'b0;
        gen_rst_d   = 1'b0;
        input_en_d  = 1'b1;
      end
      S_PAUSE, S_RESULT: begin
        timer_clr_d = 1'b0;
        gen_rst_d   = 1'b0;
      end
      default: begin
        timer_clr_d = 1'b1;
        gen_rst_d   = 1'b1;
      end
    endcase
    pulse_d = (state_q == S_TAIL) && (state_d == S_RESULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_en_q  <= 1'b0;
      timer_clr_q <= 1'b1;
      gen_rst_q   <= 1'b1;
      input_en_q  <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      timer_en_q  <= timer_en_d;
      timer_clr_q <= timer_clr_d;
      gen_rst_q   <= gen_rst_d;
      input_en_q  <= input_en_d;
      pulse_q     <= pulse_d;
    end
  end

  assign bus.o_state        = state_q;
  assign bus.o_timer_en     = timer_en_q;
  assign bus.o_timer_clr    = timer_clr_q;
  assign bus.o_gen_rst      = gen_rst_q;
  assign bus.o_input_en     = input_en_q;
  assign bus.o_digit        = digit_q;
  assign bus.o_result_pulse = pulse_q;

endmodule
